z16_ctrl_fsm: RTL and testbench

//  Multi-cycle control sequencer for the Z16 core. Owns the PC and instruction register (IR).

---
 rtl/z16_ctrl_fsm.sv | 130 +++++++++++++
 tb/tb_z16_ctrl_fsm.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z16_ctrl_fsm.sv
// z16_ctrl_fsm: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the Z16 core.
// Owns the PC, the IR and the retired-instruction counter; all strobes decode from state.
module z16_ctrl_fsm #(
    parameter int                  PC_WIDTH    = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int                  MEM_TIMEOUT = 15,
    parameter int                  RET_WIDTH   = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    output logic                 o_imem_req,
    output logic [PC_WIDTH-1:0]  o_pc,
    input  logic                 i_imem_ack,
    input  logic [15:0]          i_imem_data,
    output logic [15:0]          o_instr,
    input  logic [3:0]           i_opcode,
    input  logic                 i_rd_wen,
    input  logic                 i_mem_wen,
    input  logic                 i_branch_taken,
    input  logic [PC_WIDTH-1:0]  i_target,
    output logic                 o_rf_wen,
    output logic [1:0]           o_wb_sel,
    output logic                 o_dmem_req,
    output logic                 o_dmem_we,
    input  logic                 i_dmem_ack,
    input  logic                 i_halt,
    output logic                 o_halted,
    output logic                 o_err,
    output logic [RET_WIDTH-1:0] o_retired,
    output logic [2:0]           o_state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    localparam logic [3:0] OP_LOAD  = 4'hA;
    localparam logic [3:0] OP_STORE = 4'hB;
    localparam logic [3:0] OP_JMP   = 4'hC;
    localparam logic [3:0] OP_JAL   = 4'hD;
    localparam logic [3:0] OP_BR0   = 4'hE;
    localparam logic [3:0] OP_BR1   = 4'hF;

    // Last no-ack count before the access is declared dead.
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    logic [2:0]           state;
    logic [2:0]           state_nxt;
    logic [PC_WIDTH-1:0]  pc;
    logic [15:0]          ir;
    logic [RET_WIDTH-1:0] retired;
    logic [7:0]           tmo_cnt;

    logic is_mem_op;
    logic is_jump;
    logic is_branch;
    logic redirect;

    assign is_mem_op = (i_opcode == OP_LOAD) || (i_opcode == OP_STORE);
    assign is_jump   = (i_opcode == OP_JMP)  || (i_opcode == OP_JAL);
    assign is_branch = (i_opcode == OP_BR0)  || (i_opcode == OP_BR1);
    assign redirect  = is_jump || (is_branch && i_branch_taken);

    always_comb begin
        // NOTE: default assignment first keeps this combinational block free of latches.
        state_nxt = state;
        case (state)
            S_IDLE:   state_nxt = i_halt ? S_HALT : S_FETCH;
            S_FETCH:  if (i_imem_ack) state_nxt = S_DECODE;
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC:   state_nxt = is_mem_op ? S_MEM : S_WB;
            S_MEM: begin
                if (i_dmem_ack)               state_nxt = S_WB;
                else if (tmo_cnt == TMO_LAST) state_nxt = S_ERR;
            end
            S_WB:     state_nxt = i_halt ? S_HALT : S_FETCH;
            S_HALT:   if (!i_halt) state_nxt = S_FETCH;
            S_ERR:    state_nxt = S_ERR;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= S_IDLE;
            pc      <= RESET_PC;
            ir      <= '0;
            retired <= '0;
            tmo_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            state <= state_nxt;

            if (state == S_FETCH && i_imem_ack)
                ir <= i_imem_data;

            if (state == S_EXEC)
                tmo_cnt <= '0;
            else if (state == S_MEM && !i_dmem_ack)
                tmo_cnt <= tmo_cnt + 8'd1;

            if (state == S_WB) begin
                pc      <= redirect ? i_target : pc + PC_WIDTH'(2);
                retired <= retired + RET_WIDTH'(1);
            end
        end
    end

    // Strobes depend on registered state plus stable decoder outputs, never on acks.
    assign o_imem_req = (state == S_FETCH);
    assign o_dmem_req = (state == S_MEM);
    assign o_dmem_we  = (state == S_MEM) && i_mem_wen;
    assign o_rf_wen   = (state == S_WB) && i_rd_wen;
    assign o_wb_sel   = (state != S_WB)        ? 2'd0 :
                        (i_opcode == OP_LOAD)  ? 2'd1 :
                        is_jump                ? 2'd2 : 2'd0;

    assign o_halted  = (state == S_HALT);
    assign o_err     = (state == S_ERR);
    assign o_pc      = pc;
    assign o_instr   = ir;
    assign o_retired = retired;
    assign o_state   = state;

endmodule

// File: tb/tb_z16_ctrl_fsm.sv
// Self-checking bench for z16_ctrl_fsm: directed corner cases plus a randomized instruction
// stream compared against an instruction-level reference model (PC, retire count, strobes).
module tb_z16_ctrl_fsm;

    localparam int              PCW    = 16;
    localparam int              RETW   = 4;
    localparam int              TMO    = 15;
    localparam logic [PCW-1:0]  RST_PC = 16'h0000;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic            o_imem_req;
    logic [PCW-1:0]  o_pc;
    logic            i_imem_ack;
    logic [15:0]     i_imem_data;
    logic [15:0]     o_instr;
    logic [3:0]      i_opcode;
    logic            i_rd_wen;
    logic            i_mem_wen;
    logic            i_branch_taken;
    logic [PCW-1:0]  i_target;
    logic            o_rf_wen;
    logic [1:0]      o_wb_sel;
    logic            o_dmem_req;
    logic            o_dmem_we;
    logic            i_dmem_ack;
    logic            i_halt;
    logic            o_halted;
    logic            o_err;
    logic [RETW-1:0] o_retired;
    logic [2:0]      o_state;

    always #5 i_clk = ~i_clk;

    z16_ctrl_fsm #(
        .PC_WIDTH    (PCW),
        .RESET_PC    (RST_PC),
        .MEM_TIMEOUT (TMO),
        .RET_WIDTH   (RETW)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .o_imem_req     (o_imem_req),
        .o_pc           (o_pc),
        .i_imem_ack     (i_imem_ack),
        .i_imem_data    (i_imem_data),
        .o_instr        (o_instr),
        .i_opcode       (i_opcode),
        .i_rd_wen       (i_rd_wen),
        .i_mem_wen      (i_mem_wen),
        .i_branch_taken (i_branch_taken),
        .i_target       (i_target),
        .o_rf_wen       (o_rf_wen),
        .o_wb_sel       (o_wb_sel),
        .o_dmem_req     (o_dmem_req),
        .o_dmem_we      (o_dmem_we),
        .i_dmem_ack     (i_dmem_ack),
        .i_halt         (i_halt),
        .o_halted       (o_halted),
        .o_err          (o_err),
        .o_retired      (o_retired),
        .o_state        (o_state)
    );

    // Reference decoder: stores and branches do not write the register file.
    function automatic logic rd_wen_of(input logic [3:0] op);
        return !(op == 4'hB || op == 4'hE || op == 4'hF);
    endfunction

    function automatic logic [1:0] wb_sel_of(input logic [3:0] op);
        if (op == 4'hA) return 2'd1;
        if (op == 4'hC || op == 4'hD) return 2'd2;
        return 2'd0;
    endfunction

    assign i_opcode  = o_instr[3:0];
    assign i_rd_wen  = rd_wen_of(o_instr[3:0]);
    assign i_mem_wen = (o_instr[3:0] == 4'hB);

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: architectural PC and total retired instructions.
    int m_pc  = 0;
    int m_ret = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
    endtask

    // FETCH through EXEC for one instruction; returns at the first post-EXEC negedge.
    task automatic front(input logic [15:0] ir, input int ack_dly, input logic taken,
                         input logic [15:0] tgt, input logic halt_req);
        check("fetch_state", o_state, 32'd1);
        check("fetch_req", o_imem_req, 32'd1);
        check("fetch_pc", o_pc, m_pc);
        for (int k = 0; k < ack_dly; k++) begin
            i_imem_data = 16'($urandom);
            i_dmem_ack  = 1'($urandom);
            tick();
            check("fetch_wait_req", o_imem_req, 32'd1);
        end
        i_imem_ack  = 1'b1;
        i_imem_data = ir;
        i_dmem_ack  = 1'b0;
        tick();
        // Spurious acks during DECODE/EXEC must be ignored.
        i_imem_ack     = 1'($urandom);
        i_imem_data    = 16'($urandom);
        i_dmem_ack     = 1'($urandom);
        i_branch_taken = taken;
        i_target       = tgt;
        check("dec_state", o_state, 32'd2);
        check("ir", o_instr, ir);
        check("dec_strobes", {o_imem_req, o_dmem_req, o_rf_wen}, 32'd0);
        tick();
        if (halt_req) i_halt = 1'b1;
        check("exec_state", o_state, 32'd3);
        check("ir_hold", o_instr, ir);
        tick();
        i_imem_ack = 1'b0;
        i_dmem_ack = 1'b0;
    endtask

    task automatic run_instr(input logic [15:0] ir, input int ack_dly, input int dmem_dly,
                             input logic taken, input logic [15:0] tgt,
                             input logic halt_req, input int halt_hold);
        logic [3:0] op;
        op = ir[3:0];
        front(ir, ack_dly, taken, tgt, halt_req);
        if (op == 4'hA || op == 4'hB) begin
            for (int k = 0; k <= dmem_dly; k++) begin
                check("mem_state", o_state, 32'd4);
                check("dmem_req", o_dmem_req, 32'd1);
                check("dmem_we", o_dmem_we, op == 4'hB);
                check("mem_rf_wen", o_rf_wen, 32'd0);
                i_dmem_ack = (k == dmem_dly);
                tick();
            end
            i_dmem_ack = 1'b0;
        end
        check("wb_state", o_state, 32'd5);
        check("wb_rf_wen", o_rf_wen, rd_wen_of(op));
        check("wb_sel", o_wb_sel, wb_sel_of(op));
        check("wb_dmem_req", o_dmem_req, 32'd0);
        check("wb_ir", o_instr, ir);
        check("retired_pre", o_retired, m_ret % (1 << RETW));
        i_dmem_ack = 1'($urandom);
        tick();
        i_dmem_ack = 1'b0;

        if (op == 4'hC || op == 4'hD || ((op == 4'hE || op == 4'hF) && taken))
            m_pc = int'(tgt);
        else
            m_pc = (m_pc + 2) % 65536;
        m_ret++;

        check("retired", o_retired, m_ret % (1 << RETW));
        check("post_wb_rf_wen", o_rf_wen, 32'd0);
        check("post_wb_wb_sel", o_wb_sel, 32'd0);
        if (halt_req) begin
            for (int k = 0; k < halt_hold; k++) begin
                check("halted", o_halted, 32'd1);
                check("halt_pc", o_pc, m_pc);
                check("halt_ir", o_instr, ir);
                check("halt_req", o_imem_req, 32'd0);
                i_imem_ack = 1'($urandom);
                tick();
            end
            check("halted_last", o_halted, 32'd1);
            i_halt     = 1'b0;
            i_imem_ack = 1'b0;
            tick();
        end
        check("no_err", o_err, 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_state"}, o_state, 32'd0);
        check({tag, "_pc"}, o_pc, RST_PC);
        check({tag, "_ir"}, o_instr, 32'd0);
        check({tag, "_retired"}, o_retired, 32'd0);
        check({tag, "_strobes"}, {o_imem_req, o_dmem_req, o_dmem_we, o_rf_wen}, 32'd0);
        check({tag, "_wb_sel"}, o_wb_sel, 32'd0);
        check({tag, "_err"}, o_err, 32'd0);
        m_pc  = int'(RST_PC);
        m_ret = 0;
    endtask

    initial begin
        logic [15:0] ir;
        logic [15:0] tgt;

        i_rst = 1'b1;
        i_imem_ack = 1'b0; i_imem_data = '0; i_dmem_ack = 1'b0; i_halt = 1'b0;
        i_branch_taken = 1'b0; i_target = '0;
        tick(); tick();
        check_reset_state("rst");
        i_rst = 1'b0;
        tick();

        // Directed: ALU, load with late ack, store, jump, branches, PC wrap.
        run_instr(16'h1231, 0, 0, 1'b0, 16'h0000, 1'b0, 0);
        check("alu_pc", o_pc, 32'h2);
        run_instr(16'h123A, 1, 3, 1'b0, 16'h0000, 1'b0, 0);
        run_instr(16'h456B, 0, 0, 1'b0, 16'h0000, 1'b0, 0);
        run_instr(16'h000C, 0, 0, 1'b0, 16'h0040, 1'b0, 0);
        check("jump_pc", o_pc, 32'h40);
        run_instr(16'h000E, 0, 0, 1'b0, 16'h0080, 1'b0, 0);
        check("br_nt_pc", o_pc, 32'h42);
        run_instr(16'h000E, 0, 0, 1'b1, 16'h0010, 1'b0, 0);
        check("br_t_pc", o_pc, 32'h10);
        run_instr(16'h000D, 2, 0, 1'b0, 16'hFFFE, 1'b0, 0);
        run_instr(16'h0002, 0, 0, 1'b1, 16'h1234, 1'b0, 0);
        check("pc_wrap", o_pc, 32'h0);
        // Ack arriving on the last allowed MEM cycle still completes.
        run_instr(16'h00AA, 0, TMO - 1, 1'b0, 16'h0000, 1'b0, 0);
        // Halt raised mid-EXEC lets the instruction finish first.
        run_instr(16'h0031, 0, 0, 1'b0, 16'h0000, 1'b1, 3);

        // Randomized stream; retire counter wraps several times at RETW=4.
        for (int n = 0; n < 80; n++) begin
            ir  = 16'($urandom);
            tgt = 16'($urandom) & 16'hFFFE;
            run_instr(ir, $urandom_range(0, 2), $urandom_range(0, 4), 1'($urandom), tgt,
                      ($urandom_range(0, 7) == 0), $urandom_range(1, 3));
        end

        // Data-memory timeout -> sticky ERR, cleared only by reset.
        front(16'h777A, 0, 1'b0, 16'h0000, 1'b0);
        for (int k = 0; k < TMO; k++) begin
            check("tmo_mem_state", o_state, 32'd4);
            check("tmo_dmem_req", o_dmem_req, 32'd1);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            check("err_state", o_state, 32'd7);
            check("err_flag", o_err, 32'd1);
            check("err_strobes", {o_imem_req, o_dmem_req, o_dmem_we, o_rf_wen, o_halted}, 32'd0);
            i_dmem_ack = 1'b1; i_imem_ack = 1'b1; i_halt = 1'($urandom);
            tick();
        end
        i_dmem_ack = 1'b0; i_imem_ack = 1'b0; i_halt = 1'b0;
        i_rst = 1'b1;
        #1;
        check_reset_state("rst_err");
        tick();
        i_rst = 1'b0;
        tick();

        // Reset asserted asynchronously in the middle of a memory access.
        run_instr(16'h0005, 0, 0, 1'b0, 16'h0000, 1'b0, 0);
        front(16'h888B, 1, 1'b0, 16'h0000, 1'b0);
        tick(); tick();
        check("pre_rst_mem", o_state, 32'd4);
        i_rst = 1'b1;
        #1;
        check_reset_state("rst_mem");
        tick();
        check("rst_hold_state", o_state, 32'd0);
        i_rst = 1'b0;
        tick();

        // Halt requested while leaving reset: IDLE goes straight to HALT.
        run_instr(16'h0006, 0, 0, 1'b0, 16'h0000, 1'b0, 0);
        i_halt = 1'b1;
        i_rst  = 1'b1;
        #1;
        check_reset_state("rst_halt");
        tick();
        i_rst = 1'b0;
        tick();
        check("idle_to_halt", o_halted, 32'd1);
        check("idle_halt_pc", o_pc, RST_PC);
        i_halt = 1'b0;
        tick();
        run_instr(16'h0107, 0, 0, 1'b0, 16'h0000, 1'b0, 0);
        check("final_pc", o_pc, 32'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
